// File: rtl/corner_pkg.sv
// -----------------------------------------------------------------------------
// corner_pkg
//   Shared types and helpers for the corner locator.
//   - coord_t  : 10-bit row or column coordinate.
//   - addr_t   : packed {row, col} pixel address, 20 bits.
//   - state_t  : frame FSM states (SCAN, REPORT).
//   - stage1_t : classified pixel as registered by marker_classifier.
//   - diag_sum / diag_diff : corner metrics s = row+col and d = row-col.
// -----------------------------------------------------------------------------
package corner_pkg;

    localparam int CNT_W = 20;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } addr_t;

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        REPORT = 1'b1
    } state_t;

    typedef struct packed {
        logic  valid;
        logic  marker;
        logic  last;
        addr_t pos;
    } stage1_t;

    // Anti-diagonal metric: smallest at the upper-left, largest at the lower-right.
    function automatic logic [10:0] diag_sum(input addr_t a);
        return {1'b0, a.row} + {1'b0, a.col};
    endfunction

    // Diagonal metric: most negative at the upper-right, largest at the lower-left.
    // The range -799..599 fits an 11-bit two's-complement value.
    function automatic logic signed [10:0] diag_diff(input addr_t a);
        return signed'({1'b0, a.row} - {1'b0, a.col});
    endfunction

endpackage

// File: rtl/marker_classifier.sv
// -----------------------------------------------------------------------------
// marker_classifier
//   Stage 1 of the corner locator: thresholds one RGB pixel and registers the
//   result together with its raster position and an end-of-frame flag.
//
//   Ports:
//     i_clk       system clock
//     i_rst       asynchronous reset, active-high
//     i_valid     pixel strobe
//     i_cam_data  {2'b0, R[29:20], G[19:10], B[9:0]}
//     i_pos       raster position of the pixel on i_cam_data
//     o_s1        registered {valid, marker, last, pos}
// -----------------------------------------------------------------------------
module marker_classifier
    import corner_pkg::*;
#(
    parameter int         H_ACTIVE = 800,
    parameter int         V_ACTIVE = 600,
    parameter logic [9:0] R_MIN    = 10'd600,
    parameter logic [9:0] G_MAX    = 10'd300,
    parameter logic [9:0] B_MAX    = 10'd300
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_cam_data,
    input  addr_t       i_pos,
    output stage1_t     o_s1
);

    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
    logic       is_marker;
    logic       is_last;
    logic       unused_pad_bits;

    assign red   = i_cam_data[29:20];
    assign green = i_cam_data[19:10];
    assign blue  = i_cam_data[9:0];

    // The top two bits of the camera word are padding.
    assign unused_pad_bits = ^i_cam_data[31:30];

    assign is_marker = (red >= R_MIN) && (green <= G_MAX) && (blue <= B_MAX);
    assign is_last   = (i_pos.row == coord_t'(V_ACTIVE - 1)) &&
                       (i_pos.col == coord_t'(H_ACTIVE - 1));

    // NOTE: sequential state is written with <= so every register samples the
    //       pre-edge values; = here would make results depend on block order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_s1 <= '0;
        end else begin
            o_s1.valid  <= i_valid;
            o_s1.marker <= is_marker;
            o_s1.last   <= i_valid && is_last;
            o_s1.pos    <= i_pos;
        end
    end

endmodule

// File: rtl/corner_locator.sv
// -----------------------------------------------------------------------------
// corner_locator
//   Classifies camera pixels as marker / non-marker, tracks the four extreme
//   marker pixels of each frame and publishes them with a one-cycle pulse at
//   end of frame for the overlay stage.
//
//   Ports:
//     i_clk         system clock
//     i_rst         asynchronous reset, active-high
//     i_valid       pixel strobe; the raster advances only when set
//     i_cam_data    {2'b0, R[29:20], G[19:10], B[9:0]}
//     i_pause       hold the reported corners (sampled in the REPORT cycle)
//     o_addr_valid  one-cycle pulse: new corner set and enable on outputs
//     o_enable      marker found in the last reported frame
//     o_ul_addr     {row, col} upper-left corner
//     o_ur_addr     {row, col} upper-right corner
//     o_dl_addr     {row, col} lower-left corner
//     o_dr_addr     {row, col} lower-right corner
// -----------------------------------------------------------------------------
module corner_locator
    import corner_pkg::*;
#(
    parameter int         H_ACTIVE   = 800,
    parameter int         V_ACTIVE   = 600,
    parameter logic [9:0] R_MIN      = 10'd600,
    parameter logic [9:0] G_MAX      = 10'd300,
    parameter logic [9:0] B_MAX      = 10'd300,
    parameter int         MIN_PIXELS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_cam_data,
    input  logic        i_pause,
    output logic        o_addr_valid,
    output logic        o_enable,
    output logic [19:0] o_ul_addr,
    output logic [19:0] o_ur_addr,
    output logic [19:0] o_dl_addr,
    output logic [19:0] o_dr_addr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

    addr_t             pos;
    stage1_t           s1;
    state_t            state;
    state_t            state_d;

    logic              seen_q;
    addr_t             ul_q;
    addr_t             ur_q;
    addr_t             dl_q;
    addr_t             dr_q;
    logic [CNT_W-1:0]  count_q;

    logic              base_seen;
    addr_t             base_ul;
    addr_t             base_ur;
    addr_t             base_dl;
    addr_t             base_dr;
    logic [CNT_W-1:0]  base_count;

    logic              seen_d;
    addr_t             ul_d;
    addr_t             ur_d;
    addr_t             dl_d;
    addr_t             dr_d;
    logic [CNT_W-1:0]  count_d;

    logic              enable_now;

    // ---------------------------------------------------------------- raster
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos <= '0;
        end else if (i_valid) begin
            if (pos.col == coord_t'(H_ACTIVE - 1)) begin
                pos.col <= '0;
                pos.row <= (pos.row == coord_t'(V_ACTIVE - 1)) ? '0 : pos.row + 1'b1;
            end else begin
                pos.col <= pos.col + 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- stage 1
    marker_classifier #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .R_MIN    (R_MIN),
        .G_MAX    (G_MAX),
        .B_MAX    (B_MAX)
    ) u_classifier (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_cam_data (i_cam_data),
        .i_pos      (pos),
        .o_s1       (s1)
    );

    // --------------------------------------------------- stage 2 accumulation
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        //       leaves one unassigned, which would infer a latch.
        base_seen  = seen_q;
        base_ul    = ul_q;
        base_ur    = ur_q;
        base_dl    = dl_q;
        base_dr    = dr_q;
        base_count = count_q;

        // The REPORT cycle drops the finished frame, but a pixel arriving in
        // that same cycle is the first of the new frame and is merged below.
        if (state == REPORT) begin
            base_seen  = 1'b0;
            base_ul    = '0;
            base_ur    = '0;
            base_dl    = '0;
            base_dr    = '0;
            base_count = '0;
        end

        seen_d  = base_seen;
        ul_d    = base_ul;
        ur_d    = base_ur;
        dl_d    = base_dl;
        dr_d    = base_dr;
        count_d = base_count;

        if (s1.valid && s1.marker) begin
            seen_d = 1'b1;
            if (!base_seen) begin
                ul_d = s1.pos;
                ur_d = s1.pos;
                dl_d = s1.pos;
                dr_d = s1.pos;
            end else begin
                // Strict compares keep the earliest pixel in raster order on ties.
                if (diag_sum(s1.pos)  < diag_sum(base_ul))  ul_d = s1.pos;
                if (diag_sum(s1.pos)  > diag_sum(base_dr))  dr_d = s1.pos;
                if (diag_diff(s1.pos) < diag_diff(base_ur)) ur_d = s1.pos;
                if (diag_diff(s1.pos) > diag_diff(base_dl)) dl_d = s1.pos;
            end
            if (base_count != CNT_MAX) begin
                count_d = base_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seen_q  <= 1'b0;
            ul_q    <= '0;
            ur_q    <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
            count_q <= '0;
        end else begin
            seen_q  <= seen_d;
            ul_q    <= ul_d;
            ur_q    <= ur_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------- FSM
    always_comb begin
        state_d = SCAN;
        if (state == SCAN && s1.valid && s1.last) begin
            state_d = REPORT;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= SCAN;
        end else begin
            state <= state_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    // In the REPORT cycle the accumulators still hold the finished frame.
    assign enable_now = (count_q >= CNT_MIN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_addr_valid <= 1'b0;
            o_enable     <= 1'b0;
            o_ul_addr    <= '0;
            o_ur_addr    <= '0;
            o_dl_addr    <= '0;
            o_dr_addr    <= '0;
        end else begin
            o_addr_valid <= 1'b0;
            if (state == REPORT && !i_pause) begin
                o_addr_valid <= 1'b1;
                o_enable     <= enable_now;
                if (enable_now) begin
                    o_ul_addr <= ul_q;
                    o_ur_addr <= ur_q;
                    o_dl_addr <= dl_q;
                    o_dr_addr <= dr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_corner_locator.sv
// -----------------------------------------------------------------------------
// tb_corner_locator
//   Directed frame-level bench for corner_locator on a reduced 24x16 raster
//   (thresholds and MIN_PIXELS at their defaults). Each table entry describes
//   one frame's marker shape and the hand-computed corners it must report.
// -----------------------------------------------------------------------------
module tb_corner_locator;

    localparam int H = 24;
    localparam int V = 16;

    localparam logic [31:0] BLACK = 32'h0;
    localparam logic [31:0] RED   = {2'b00, 10'd1023, 10'd0,   10'd0};
    localparam logic [31:0] BND   = {2'b00, 10'd600,  10'd300, 10'd300};
    localparam logic [31:0] NR    = {2'b00, 10'd599,  10'd0,   10'd0};
    localparam logic [31:0] NG    = {2'b00, 10'd1023, 10'd301, 10'd0};
    localparam logic [31:0] NB    = {2'b00, 10'd1023, 10'd0,   10'd301};

    // kind: 0 = rectangle r0..r0+h-1 x c0..c0+w-1
    //       1 = anti-diagonal, col = c0 - (row - r0), h rows
    //       2 = diagonal,      col = c0 + (row - r0), h rows
    typedef struct {
        int          kind;
        int          r0;
        int          c0;
        int          h;
        int          w;
        logic [31:0] color;
        bit          near;
        bit          pause;
        bit          gaps;
        bit          exp_en;
        logic [19:0] ul;
        logic [19:0] ur;
        logic [19:0] dl;
        logic [19:0] dr;
    } frame_vec_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_cam_data;
    logic        i_pause;
    logic        o_addr_valid;
    logic        o_enable;
    logic [19:0] o_ul_addr;
    logic [19:0] o_ur_addr;
    logic [19:0] o_dl_addr;
    logic [19:0] o_dr_addr;

    int          n_pos   = 0;
    int          chk_pos = -1;
    int          n_vec   = 0;
    int          n_bad   = 0;

    logic        exp_pulse = 1'b0;
    logic        mdl_en    = 1'b0;
    logic [19:0] mdl_ul    = '0;
    logic [19:0] mdl_ur    = '0;
    logic [19:0] mdl_dl    = '0;
    logic [19:0] mdl_dr    = '0;

    frame_vec_t  vecs [9];

    corner_locator #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_cam_data   (i_cam_data),
        .i_pause      (i_pause),
        .o_addr_valid (o_addr_valid),
        .o_enable     (o_enable),
        .o_ul_addr    (o_ul_addr),
        .o_ur_addr    (o_ur_addr),
        .o_dl_addr    (o_dl_addr),
        .o_dr_addr    (o_dr_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) n_pos <= n_pos + 1;

    function automatic logic [19:0] mk(input int r, input int c);
        return {10'(r), 10'(c)};
    endfunction

    function automatic logic [31:0] pix(input frame_vec_t f, input int r, input int c);
        bit hit;
        case (f.kind)
            0:       hit = (r >= f.r0) && (r < f.r0 + f.h) && (c >= f.c0) && (c < f.c0 + f.w);
            1:       hit = (r >= f.r0) && (r < f.r0 + f.h) && (c == f.c0 - (r - f.r0));
            default: hit = (r >= f.r0) && (r < f.r0 + f.h) && (c == f.c0 + (r - f.r0));
        endcase
        if (hit) return f.color;
        // Row 10 carries eight each of three just-outside-threshold colours.
        if (f.near && r == 10) begin
            case (c % 3)
                0:       return NR;
                1:       return NG;
                default: return NB;
            endcase
        end
        return BLACK;
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: reset values, the scheduled end-of-frame check, and
    // any pulse outside a scheduled slot.
    always @(negedge i_clk) begin
        if (i_rst) begin
            check("rst_addr_valid", 20'(o_addr_valid), 20'd0);
            check("rst_enable",     20'(o_enable),     20'd0);
            check("rst_ul",         o_ul_addr,         20'd0);
            check("rst_ur",         o_ur_addr,         20'd0);
            check("rst_dl",         o_dl_addr,         20'd0);
            check("rst_dr",         o_dr_addr,         20'd0);
        end else if (n_pos == chk_pos) begin
            check("addr_valid", 20'(o_addr_valid), 20'(exp_pulse));
            check("enable",     20'(o_enable),     20'(mdl_en));
            check("ul_addr",    o_ul_addr,         mdl_ul);
            check("ur_addr",    o_ur_addr,         mdl_ur);
            check("dl_addr",    o_dl_addr,         mdl_dl);
            check("dr_addr",    o_dr_addr,         mdl_dr);
        end else if (o_addr_valid) begin
            check("stray_pulse", 20'(o_addr_valid), 20'd0);
        end
    end

    // Drives the first n pixels of frame f; with arm set, schedules the
    // end-of-frame check two cycles after the edge sampling the last pixel.
    task automatic run_pixels(input frame_vec_t f, input int n, input bit arm);
        int idx;
        int last_p;
        idx    = 0;
        last_p = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (idx < n) begin
                    if (f.gaps) begin
                        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                            @(negedge i_clk);
                            i_valid    = 1'b0;
                            i_cam_data = 32'hdead_beef;
                        end
                    end
                    @(negedge i_clk);
                    // Pause switches mid-frame so it is stable over the REPORT
                    // cycle of the previous frame's end.
                    if (r == 1 && c == 0) i_pause = f.pause;
                    i_valid    = 1'b1;
                    i_cam_data = pix(f, r, c);
                    last_p     = n_pos;
                    idx++;
                end
            end
        end
        if (arm) begin
            exp_pulse = !f.pause;
            if (!f.pause) begin
                mdl_en = f.exp_en;
                if (f.exp_en) begin
                    mdl_ul = f.ul;
                    mdl_ur = f.ur;
                    mdl_dl = f.dl;
                    mdl_dr = f.dr;
                end
            end
            chk_pos = last_p + 3;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_valid    = 1'b0;
            i_cam_data = BLACK;
        end
    endtask

    initial begin
        frame_vec_t f;

        //             kind r0 c0  h  w  color near pause gaps en  ul          ur          dl          dr
        vecs[0] = '{0,  5, 10, 4, 4, RED,   0, 0, 0, 1, mk(5,10),  mk(5,13),  mk(8,10),  mk(8,13)};
        vecs[1] = '{0,  0,  0, 0, 0, BLACK, 0, 0, 0, 0, mk(0,0),   mk(0,0),   mk(0,0),   mk(0,0)};
        vecs[2] = '{0,  2,  3, 3, 3, BND,   1, 0, 0, 0, mk(2,3),   mk(2,5),   mk(4,3),   mk(4,5)};
        vecs[3] = '{0, 12, 20, 4, 4, BND,   0, 0, 0, 1, mk(12,20), mk(12,23), mk(15,20), mk(15,23)};
        vecs[4] = '{0,  1,  1, 4, 4, RED,   0, 1, 0, 1, mk(1,1),   mk(1,4),   mk(4,1),   mk(4,4)};
        vecs[5] = '{0,  0,  0, 4, 4, RED,   0, 0, 0, 1, mk(0,0),   mk(0,3),   mk(3,0),   mk(3,3)};
        vecs[6] = '{0,  5, 10, 4, 4, RED,   0, 0, 1, 1, mk(5,10),  mk(5,13),  mk(8,10),  mk(8,13)};
        vecs[7] = '{1,  0, 20, 16, 1, RED,  0, 0, 0, 1, mk(0,20),  mk(0,20),  mk(15,5),  mk(0,20)};
        vecs[8] = '{2,  0,  4, 16, 1, RED,  0, 0, 0, 1, mk(0,4),   mk(0,4),   mk(0,4),   mk(15,19)};

        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_cam_data = BLACK;
        i_pause    = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b0;

        // Frames stream back to back so each new frame's first pixel lands in
        // the previous frame's REPORT cycle.
        for (int i = 0; i < 9; i++) begin
            run_pixels(vecs[i], H * V, 1'b1);
        end
        idle(6);

        // Partial frame with a block at the origin, then reset mid-frame.
        f = '{0, 0, 0, 4, 4, RED, 0, 0, 0, 1, mk(0,0), mk(0,3), mk(3,0), mk(3,3)};
        run_pixels(f, 7 * H + 5, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b0;
        #2 i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b0;
        mdl_en = 1'b0;
        mdl_ul = '0;
        mdl_ur = '0;
        mdl_dl = '0;
        mdl_dr = '0;

        f = '{0, 9, 6, 4, 4, RED, 0, 0, 0, 1, mk(9,6), mk(9,9), mk(12,6), mk(12,9)};
        run_pixels(f, H * V, 1'b1);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/corner_locator.md
Name: corner_locator

Overview:
- Sits directly upstream of the camera-overlay image generator on the camera pixel stream.
- Classifies each incoming camera pixel as marker or non-marker using RGB thresholds.
- Tracks the four extreme marker pixels (upper-left, upper-right, lower-left, lower-right) over each 800x600 frame.
- At end of frame, publishes the four corner addresses plus an enable flag with a one-cycle valid pulse; these feed the overlay stage's corner-address inputs.

Parameters:
- H_ACTIVE, 800, pixels per line.
- V_ACTIVE, 600, lines per frame.
- R_MIN, 10'd600, marker pixel requires R >= R_MIN.
- G_MAX, 10'd300, marker pixel requires G <= G_MAX.
- B_MAX, 10'd300, marker pixel requires B <= B_MAX.
- MIN_PIXELS, 16, minimum marker-pixel count for a frame to be reported as enabled.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  pixel strobe; the raster advances only on cycles with i_valid=1.
- i_cam_data  in  32  pixel {2'b0, R[29:20], G[19:10], B[9:0]}.
- i_pause  in  1  freeze reported corners.
- o_addr_valid  out  1  one-cycle pulse; new corner set and enable flag on outputs.
- o_enable  out  1  1 = marker found in last reported frame.
- o_ul_addr  out  20  {row[19:10], col[9:0]} of upper-left corner.
- o_ur_addr  out  20  upper-right corner, same format.
- o_dl_addr  out  20  lower-left corner, same format.
- o_dr_addr  out  20  lower-right corner, same format.

Behaviour:
- Reset: all outputs 0; row/col counters 0; accumulators cleared; FSM in SCAN. A reset mid-frame discards the partial frame; the raster origin is the first valid pixel after reset.
- Raster counters:
  - col increments on i_valid; wraps H_ACTIVE-1 -> 0 and increments row.
  - row wraps V_ACTIVE-1 -> 0.
  - Gaps in i_valid freeze both counters.
- Stage 1 (registered, 1 cycle): marker = (R>=R_MIN)&&(G<=G_MAX)&&(B<=B_MAX), registered together with row, col, valid and last-pixel flag (row=V_ACTIVE-1 and col=H_ACTIVE-1).
- Stage 2 accumulation, only on registered valid && marker:
  - UL: minimise s=row+col (11-bit unsigned).
  - DR: maximise s.
  - UR: minimise d=row-col (11-bit signed).
  - DL: maximise d.
  - Strict compare: on ties, the first pixel in raster order wins.
  - The first marker pixel of a frame seeds all four corners.
  - count increments, saturating at 2^20-1.
- FSM states SCAN, REPORT:
  - SCAN -> REPORT on the registered last pixel, after accumulating it.
  - REPORT lasts exactly one cycle, then returns to SCAN.
  - On REPORT entry, accumulators and count clear, so the frame starting next is fresh.
- REPORT cycle, i_pause=0:
  - o_addr_valid=1.
  - o_enable = (count >= MIN_PIXELS).
  - o_*_addr load the tracked corners if enabled; otherwise they hold their previous values.
- REPORT cycle, i_pause=1: no pulse; all outputs hold. i_pause is sampled only in the REPORT cycle; accumulation is unaffected by i_pause.
- Latency: o_addr_valid rises 2 cycles after the i_valid cycle carrying pixel (599,799).
- Outputs are registered and stable between pulses.
- Pixels arriving during the REPORT cycle belong to the new frame and must be accumulated; the clear takes priority only over the old contents. Merge logic required.

Decomposition:
- Package corner_pkg:
  - Typedefs coord_t (logic[9:0]) and addr_t (struct {coord_t row; coord_t col;} packed, 20 bits).
  - Enum state_t {SCAN, REPORT}.
  - Constant CNT_W=20.
- Sub-module marker_classifier: threshold compare plus stage-1 register (valid, marker, row, col, last). Top level holds counters, accumulators and FSM.

Test Plan:
- Single red 4x4 block at rows 100-103, cols 200-203, rest black -> one pulse, o_enable=1, UL={100,200}, UR={100,203}, DL={103,200}, DR={103,203}.
- All-black frame after a good frame -> pulse with o_enable=0; addresses hold the previous values.
- Block of 3x3 = 9 pixels, below MIN_PIXELS -> o_enable=0. Block of 4x4 = 16 pixels -> o_enable=1 (boundary).
- i_pause=1 through frame end -> no pulse, outputs unchanged. Next frame with i_pause=0 reports that frame's corners only.
- Random i_valid gaps (50% duty) on the first test frame -> identical corners; pulse exactly 2 cycles after the last valid pixel.
- Assert i_rst mid-frame, then stream a full frame -> all outputs 0 during reset; the next report reflects only the post-reset frame.
